// File: rtl/latch_wr_sched_pkg.sv
// Shared types for the latch write scheduler: FSM states, requester ids and
// the legal range of the load-window length.
package latch_wr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OPEN,
    CLOSE,
    DONE
  } wr_state_t;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } req_id_t;

  localparam int OPEN_CYC_MIN = 1;
  localparam int OPEN_CYC_MAX = 4;

endpackage

// File: rtl/latch_wr_sched_if.sv
// Request/ack handshakes of both write ports plus the latch-bank drive signals.
interface latch_wr_sched_if #(
  parameter int AW    = 3,
  parameter int DW    = 8,
  parameter int NREGS = 8
);
  logic             cpu_req;
  logic [AW-1:0]    cpu_addr;
  logic [DW-1:0]    cpu_data;
  logic             cpu_ack;
  logic             dbg_req;
  logic [AW-1:0]    dbg_addr;
  logic [DW-1:0]    dbg_data;
  logic             dbg_ack;
  logic             addr_err;
  logic             phi_keep;
  logic [NREGS-1:0] en;
  logic [DW-1:0]    d;
  logic             busy;

  modport master (
    output cpu_req, cpu_addr, cpu_data, dbg_req, dbg_addr, dbg_data,
    input  cpu_ack, dbg_ack, addr_err, phi_keep, en, d, busy
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_data, dbg_req, dbg_addr, dbg_data,
    output cpu_ack, dbg_ack, addr_err, phi_keep, en, d, busy
  );
endinterface

// File: rtl/wr_rr_arb2.sv
// Two-request round-robin arbiter; the last winner only moves when the FSM
// accepts a grant, so a tie always goes to the port that was not served last.
module wr_rr_arb2
  import latch_wr_sched_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    cpu_req,
  input  logic    dbg_req,
  input  logic    accept,
  output req_id_t grant,
  output logic    any_req
);

  req_id_t rr_last_reg;

  // Reset to DBG so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_reg <= DBG;
    end else if (accept) begin
      rr_last_reg <= grant;
    end
  end

  always_comb begin
    grant = CPU;
    if (cpu_req && dbg_req) begin
      grant = (rr_last_reg == DBG) ? CPU : DBG;
    end else if (dbg_req) begin
      grant = DBG;
    end
  end

  assign any_req = cpu_req | dbg_req;

endmodule

// File: rtl/latch_wr_sched.sv
// Write scheduler for a bank of keep/load latches: arbitrates two write ports
// and sequences en/d around a phi_keep low window so exactly one latch loads.
module latch_wr_sched
  import latch_wr_sched_pkg::*;
#(
  parameter int NREGS    = 8,
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int OPEN_CYC = 1
) (
  input  logic             CLK,
  input  logic             n_RES,
  latch_wr_sched_if.slave  bus
);

  localparam logic [2:0] LAST_OPEN = 3'(OPEN_CYC - 1);

  wr_state_t        state_reg;
  req_id_t          owner_reg;
  logic [AW-1:0]    addr_reg;
  logic [DW-1:0]    data_reg;
  logic [2:0]       cnt_reg;

  logic             phi_keep_reg;
  logic [NREGS-1:0] en_reg;
  logic [DW-1:0]    d_reg;
  logic             cpu_ack_reg;
  logic             dbg_ack_reg;
  logic             addr_err_reg;
  logic             busy_reg;

  req_id_t          grant;
  logic             any_req;
  logic             accept;
  logic             in_range;
  logic [NREGS-1:0] sel;

  assign accept   = (state_reg == IDLE) && any_req;
  assign in_range = (32'(addr_reg) < NREGS);

  wr_rr_arb2 u_arb (
    .clk     (CLK),
    .rst_n   (n_RES),
    .cpu_req (bus.cpu_req),
    .dbg_req (bus.dbg_req),
    .accept  (accept),
    .grant   (grant),
    .any_req (any_req)
  );

  // Out-of-range addresses decode to no enable at all.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
      assign sel[gi] = in_range && (addr_reg == AW'(gi));
    end
  endgenerate

  // Outputs are registered from the current state, so every edge of en sits
  // one full cycle away from the phi_keep edges.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state_reg    <= IDLE;
      owner_reg    <= CPU;
      addr_reg     <= '0;
      data_reg     <= '0;
      cnt_reg      <= '0;
      phi_keep_reg <= 1'b1;
      en_reg       <= '0;
      d_reg        <= '0;
      cpu_ack_reg  <= 1'b0;
      dbg_ack_reg  <= 1'b0;
      addr_err_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      cpu_ack_reg  <= 1'b0;
      dbg_ack_reg  <= 1'b0;
      addr_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          phi_keep_reg <= 1'b1;
          en_reg       <= '0;
          if (any_req) begin
            owner_reg <= grant;
            addr_reg  <= (grant == DBG) ? bus.dbg_addr : bus.cpu_addr;
            data_reg  <= (grant == DBG) ? bus.dbg_data : bus.cpu_data;
            busy_reg  <= 1'b1;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          d_reg        <= data_reg;
          en_reg       <= sel;
          phi_keep_reg <= 1'b1;
          cnt_reg      <= '0;
          state_reg    <= OPEN;
        end
        OPEN: begin
          phi_keep_reg <= 1'b0;
          if (cnt_reg == LAST_OPEN) begin
            state_reg <= CLOSE;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        CLOSE: begin
          phi_keep_reg <= 1'b1;
          state_reg    <= DONE;
        end
        DONE: begin
          en_reg       <= '0;
          cpu_ack_reg  <= (owner_reg == CPU);
          dbg_ack_reg  <= (owner_reg == DBG);
          addr_err_reg <= !in_range;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.phi_keep = phi_keep_reg;
  assign bus.en       = en_reg;
  assign bus.d        = d_reg;
  assign bus.cpu_ack  = cpu_ack_reg;
  assign bus.dbg_ack  = dbg_ack_reg;
  assign bus.addr_err = addr_err_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_latch_wr_sched.sv
// Bench for latch_wr_sched: two instances (short and long load window) checked
// cycle by cycle against a phase-based reference model and an sdffe bank model.
module tb_latch_wr_sched;

  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int NR_A = 6;
  localparam int OC_A = 1;
  localparam int NR_B = 8;
  localparam int OC_B = 3;

  typedef struct packed {
    logic        busy;
    logic        phi;
    logic        cack;
    logic        dack;
    logic        err;
    logic [15:0] en;
    logic [7:0]  d;
  } obs_t;

  typedef struct {
    bit          who;
    int          addr;
    logic [7:0]  data;
    logic [15:0] exp_en;
    bit          exp_err;
  } vec_t;

  logic CLK = 1'b0;
  logic n_RES;
  always #5 CLK = ~CLK;

  logic          cpu_req_v  [2];
  logic [AW-1:0] cpu_addr_v [2];
  logic [DW-1:0] cpu_data_v [2];
  logic          dbg_req_v  [2];
  logic [AW-1:0] dbg_addr_v [2];
  logic [DW-1:0] dbg_data_v [2];

  latch_wr_sched_if #(.AW(AW), .DW(DW), .NREGS(NR_A)) bus_a ();
  latch_wr_sched_if #(.AW(AW), .DW(DW), .NREGS(NR_B)) bus_b ();

  assign bus_a.cpu_req  = cpu_req_v[0];
  assign bus_a.cpu_addr = cpu_addr_v[0];
  assign bus_a.cpu_data = cpu_data_v[0];
  assign bus_a.dbg_req  = dbg_req_v[0];
  assign bus_a.dbg_addr = dbg_addr_v[0];
  assign bus_a.dbg_data = dbg_data_v[0];
  assign bus_b.cpu_req  = cpu_req_v[1];
  assign bus_b.cpu_addr = cpu_addr_v[1];
  assign bus_b.cpu_data = cpu_data_v[1];
  assign bus_b.dbg_req  = dbg_req_v[1];
  assign bus_b.dbg_addr = dbg_addr_v[1];
  assign bus_b.dbg_data = dbg_data_v[1];

  latch_wr_sched #(.NREGS(NR_A), .AW(AW), .DW(DW), .OPEN_CYC(OC_A)) u_dut_a (
    .CLK   (CLK),
    .n_RES (n_RES),
    .bus   (bus_a.slave)
  );

  latch_wr_sched #(.NREGS(NR_B), .AW(AW), .DW(DW), .OPEN_CYC(OC_B)) u_dut_b (
    .CLK   (CLK),
    .n_RES (n_RES),
    .bus   (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rand_en = 1'b0;
  bit hold_cpu [2];
  bit hold_dbg [2];

  // Reference model: a write is tracked only by its phase p (cycles since the
  // grant edge); every expected output is a plain range test on p.
  bit         m_act  [2];
  int         m_p    [2];
  bit         m_who  [2];
  int         m_addr [2];
  logic [7:0] m_data [2];
  logic [7:0] m_d    [2];
  bit         m_last [2];
  logic [7:0] bank_exp [2][16];
  logic [7:0] bank_lat [2][16];
  logic [15:0] prev_en [2];
  logic        prev_phi [2];

  logic          s_creq [2];
  logic          s_dreq [2];
  logic [AW-1:0] s_caddr [2];
  logic [AW-1:0] s_daddr [2];
  logic [DW-1:0] s_cdata [2];
  logic [DW-1:0] s_ddata [2];

  function automatic int oc_of(input int k);
    return (k == 0) ? OC_A : OC_B;
  endfunction

  function automatic int nr_of(input int k);
    return (k == 0) ? NR_A : NR_B;
  endfunction

  function automatic obs_t get_obs(input int k);
    obs_t o;
    if (k == 0) begin
      o.busy = bus_a.busy;  o.phi = bus_a.phi_keep; o.cack = bus_a.cpu_ack;
      o.dack = bus_a.dbg_ack; o.err = bus_a.addr_err; o.en = 16'(bus_a.en); o.d = bus_a.d;
    end else begin
      o.busy = bus_b.busy;  o.phi = bus_b.phi_keep; o.cack = bus_b.cpu_ack;
      o.dack = bus_b.dbg_ack; o.err = bus_b.addr_err; o.en = 16'(bus_b.en); o.d = bus_b.d;
    end
    return o;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_act[k]    = 1'b0;
    m_p[k]      = 0;
    m_last[k]   = 1'b1;
    m_d[k]      = 8'h00;
    prev_en[k]  = 16'h0000;
    prev_phi[k] = 1'b1;
  endtask

  task automatic model_edge(input int k);
    bit win;
    if (m_act[k]) m_p[k]++;
    if (!m_act[k] || m_p[k] >= oc_of(k) + 4) begin
      m_act[k] = 1'b0;
      if (s_creq[k] || s_dreq[k]) begin
        if (s_creq[k] && s_dreq[k]) win = !m_last[k];
        else                        win = s_dreq[k];
        m_last[k] = win;
        m_act[k]  = 1'b1;
        m_p[k]    = 0;
        m_who[k]  = win;
        m_addr[k] = win ? int'(s_daddr[k]) : int'(s_caddr[k]);
        m_data[k] = win ? s_ddata[k] : s_cdata[k];
      end
    end
    if (m_act[k] && m_p[k] == 1) m_d[k] = m_data[k];
  endtask

  task automatic check_outputs(input int k);
    obs_t        o;
    int          oc, nr, p;
    bit          a, fin;
    logic [15:0] e_en;
    o   = get_obs(k);
    oc  = oc_of(k);
    nr  = nr_of(k);
    p   = m_p[k];
    a   = m_act[k];
    fin = a && (p == oc + 3);
    e_en = (a && p >= 1 && p <= oc + 2 && m_addr[k] < nr) ? (16'd1 << m_addr[k]) : 16'd0;
    chk("busy",     k, o.busy, a && p <= oc + 2);
    chk("phi_keep", k, o.phi,  !(a && p >= 2 && p <= oc + 1));
    chk("en",       k, o.en,   e_en);
    chk("d",        k, o.d,    m_d[k]);
    chk("cpu_ack",  k, o.cack, fin && !m_who[k]);
    chk("dbg_ack",  k, o.dack, fin && m_who[k]);
    chk("addr_err", k, o.err,  fin && m_addr[k] >= nr);
    chk("en_onehot", k, $countones(o.en) <= 1, 1);
    if (o.en !== prev_en[k]) chk("en_edge_phi", k, prev_phi[k] && o.phi, 1);
    if (o.phi === 1'b0) begin
      for (int i = 0; i < 16; i++) if (o.en[i]) bank_lat[k][i] = o.d;
    end
    prev_en[k]  = o.en;
    prev_phi[k] = o.phi;
    if (fin) begin
      if (m_addr[k] < nr) bank_exp[k][m_addr[k]] = m_data[k];
      for (int i = 0; i < nr; i++) chk("bank", k, bank_lat[k][i], bank_exp[k][i]);
      $display("dut=%0d cyc=%0d ack %s addr=%0d data=%02h addr_err=%0b",
               k, cyc, m_who[k] ? "dbg" : "cpu", m_addr[k], m_data[k], o.err);
    end
  endtask

  // Requesters hold req until their ack and drop it during the ack cycle.
  task automatic autoreq(input int k);
    obs_t o;
    o = get_obs(k);
    if (cpu_req_v[k] && o.cack && !hold_cpu[k]) cpu_req_v[k] = 1'b0;
    else if (!cpu_req_v[k] && rand_en && $urandom_range(0, 2) == 0) begin
      cpu_req_v[k]  = 1'b1;
      cpu_addr_v[k] = AW'($urandom_range(0, 7));
      cpu_data_v[k] = DW'($urandom);
    end
    if (dbg_req_v[k] && o.dack && !hold_dbg[k]) dbg_req_v[k] = 1'b0;
    else if (!dbg_req_v[k] && rand_en && $urandom_range(0, 2) == 0) begin
      dbg_req_v[k]  = 1'b1;
      dbg_addr_v[k] = AW'($urandom_range(0, 7));
      dbg_data_v[k] = DW'($urandom);
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      s_creq[k] = cpu_req_v[k];  s_caddr[k] = cpu_addr_v[k]; s_cdata[k] = cpu_data_v[k];
      s_dreq[k] = dbg_req_v[k];  s_daddr[k] = dbg_addr_v[k]; s_ddata[k] = dbg_data_v[k];
    end
    @(posedge CLK);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!n_RES) model_reset(k);
      else        model_edge(k);
      check_outputs(k);
      autoreq(k);
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = 1'b1;
    for (int k = 0; k < 2; k++)
      if (cpu_req_v[k] || dbg_req_v[k] || m_act[k]) r = 1'b0;
    return r;
  endfunction

  vec_t vt [6];
  bit   tie_exp [3];

  initial begin
    obs_t        o;
    int          n, nacks, last_n, lows;
    bit          got, seen;
    logic [15:0] en_seen;
    logic        err_seen;

    vt[0] = '{who: 1'b0, addr: 3, data: 8'hA5, exp_en: 16'h0008, exp_err: 1'b0};
    vt[1] = '{who: 1'b1, addr: 7, data: 8'h3C, exp_en: 16'h0000, exp_err: 1'b1};
    vt[2] = '{who: 1'b0, addr: 0, data: 8'h11, exp_en: 16'h0001, exp_err: 1'b0};
    vt[3] = '{who: 1'b1, addr: 5, data: 8'h22, exp_en: 16'h0020, exp_err: 1'b0};
    vt[4] = '{who: 1'b0, addr: 6, data: 8'h33, exp_en: 16'h0000, exp_err: 1'b1};
    vt[5] = '{who: 1'b1, addr: 2, data: 8'h44, exp_en: 16'h0004, exp_err: 1'b0};
    tie_exp[0] = 1'b0; tie_exp[1] = 1'b1; tie_exp[2] = 1'b0;

    n_RES = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cpu_req_v[k] = 1'b0; cpu_addr_v[k] = '0; cpu_data_v[k] = '0;
      dbg_req_v[k] = 1'b0; dbg_addr_v[k] = '0; dbg_data_v[k] = '0;
      hold_cpu[k] = 1'b0;  hold_dbg[k] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        bank_exp[k][i] = 8'h00;
        bank_lat[k][i] = 8'h00;
      end
    end

    // Reset before any clock edge, then held across a few edges.
    #2 n_RES = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      check_outputs(k);
    end
    repeat (3) tick();
    #2 n_RES = 1'b1;
    tick();

    // Single writes on the short-window instance.
    for (int i = 0; i < 6; i++) begin
      if (vt[i].who == 1'b0) begin
        cpu_req_v[0] = 1'b1; cpu_addr_v[0] = AW'(vt[i].addr); cpu_data_v[0] = vt[i].data;
      end else begin
        dbg_req_v[0] = 1'b1; dbg_addr_v[0] = AW'(vt[i].addr); dbg_data_v[0] = vt[i].data;
      end
      n = 0; got = 1'b0; en_seen = '0; err_seen = 1'b0;
      while (!got && n < 20) begin
        tick();
        n++;
        o = get_obs(0);
        en_seen |= o.en;
        if ((vt[i].who == 1'b0 && o.cack) || (vt[i].who == 1'b1 && o.dack)) begin
          got = 1'b1;
          err_seen = o.err;
        end
      end
      chk("tbl_ack_seen", 0, got, 1);
      chk("tbl_latency",  0, n, OC_A + 4);
      chk("tbl_en",       0, en_seen, vt[i].exp_en);
      chk("tbl_addr_err", 0, err_seen, vt[i].exp_err);
      if (!vt[i].exp_err) chk("tbl_latch", 0, bank_lat[0][vt[i].addr], vt[i].data);
      cpu_req_v[0] = 1'b0;
      dbg_req_v[0] = 1'b0;
      tick();
    end

    // Both ports held: grants must alternate CPU, DBG, CPU.
    hold_cpu[0] = 1'b1; hold_dbg[0] = 1'b1;
    cpu_req_v[0] = 1'b1; cpu_addr_v[0] = 3'd1; cpu_data_v[0] = 8'h5A;
    dbg_req_v[0] = 1'b1; dbg_addr_v[0] = 3'd2; dbg_data_v[0] = 8'hC3;
    n = 0; nacks = 0;
    while (nacks < 3 && n < 60) begin
      tick();
      n++;
      o = get_obs(0);
      if (o.cack || o.dack) begin
        chk("tie_order", 0, o.dack, tie_exp[nacks]);
        nacks++;
      end
    end
    chk("tie_count", 0, nacks, 3);
    cpu_req_v[0] = 1'b0; dbg_req_v[0] = 1'b0;
    hold_cpu[0] = 1'b0;  hold_dbg[0] = 1'b0;
    repeat (2) tick();

    // Back-to-back CPU writes on the long-window instance.
    hold_cpu[1] = 1'b1;
    cpu_req_v[1] = 1'b1; cpu_addr_v[1] = AW'($urandom_range(0, 7)); cpu_data_v[1] = DW'($urandom);
    n = 0; nacks = 0; last_n = 0; lows = 0;
    while (nacks < 4 && n < 80) begin
      tick();
      n++;
      o = get_obs(1);
      if (!o.phi) lows++;
      if (o.cack) begin
        if (nacks > 0) chk("b2b_gap", 1, n - last_n, OC_B + 4);
        chk("b2b_phi_low", 1, lows, OC_B);
        lows = 0; last_n = n; nacks++;
        cpu_addr_v[1] = AW'($urandom_range(0, 7));
        cpu_data_v[1] = DW'($urandom);
      end
    end
    chk("b2b_count", 1, nacks, 4);
    cpu_req_v[1] = 1'b0; hold_cpu[1] = 1'b0;
    repeat (2) tick();

    // Reset pulsed in the middle of the load window.
    cpu_req_v[0] = 1'b1; cpu_addr_v[0] = 3'd4; cpu_data_v[0] = 8'h77;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      tick();
      n++;
      o = get_obs(0);
      if (!o.phi) seen = 1'b1;
    end
    chk("rst_open_seen", 0, seen, 1);
    #3 n_RES = 1'b0;
    #1;
    cpu_req_v[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      check_outputs(k);
      for (int i = 0; i < 16; i++) bank_exp[k][i] = bank_lat[k][i];
    end
    repeat (2) tick();
    #2 n_RES = 1'b1;
    repeat (3) tick();
    cpu_req_v[0] = 1'b1; cpu_addr_v[0] = 3'd1; cpu_data_v[0] = 8'h96;
    dbg_req_v[0] = 1'b1; dbg_addr_v[0] = 3'd2; dbg_data_v[0] = 8'h69;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      o = get_obs(0);
      if (o.cack || o.dack) begin
        got = 1'b1;
        chk("rst_tie_cpu_first", 0, o.cack, 1);
      end
    end
    chk("rst_tie_ack_seen", 0, got, 1);
    n = 0;
    while (!all_idle() && n < 30) begin
      tick();
      n++;
    end
    chk("rst_tie_drain", 0, all_idle(), 1);

    // Random traffic on both instances.
    rand_en = 1'b1;
    repeat (400) tick();
    rand_en = 1'b0;
    n = 0;
    while (!all_idle() && n < 100) begin
      tick();
      n++;
    end
    chk("rand_drain", 0, all_idle(), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/latch_wr_sched.md
Name: latch_wr_sched

Overview:
- Write scheduler for a bank of single-phase keep/load latches (sdffe-style cells).
- Each cell holds while phi_keep=1 and loads d when phi_keep=0 and its en=1.
- Shares the latch bank between two requesters, a CPU write port and a debug/DMA write port, using round-robin arbitration.
- Sequences phi_keep, the one-hot en and d so that each write opens exactly one latch. d and en stay stable across both phi_keep edges.

Parameters:
- NREGS, 8, number of latches in the bank (2..16).
- AW, 3, address width; must satisfy 2^AW >= NREGS.
- DW, 8, data width.
- OPEN_CYC, 1, number of CLK cycles phi_keep is held low per write (1..4).

Ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- n_RES  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU write request, level, held until cpu_ack.
- cpu_addr  in  AW  CPU target latch index.
- cpu_data  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- dbg_req  in  1  debug write request, level, held until dbg_ack.
- dbg_addr  in  AW  debug target latch index.
- dbg_data  in  DW  debug write data.
- dbg_ack  out  1  one-cycle completion pulse to the debug port.
- addr_err  out  1  pulses together with ack when the granted address is >= NREGS.
- phi_keep  out  1  to all latches; 1 = hold, 0 = load window.
- en  out  NREGS  one-hot per-latch write enable.
- d  out  DW  shared latch write data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset:
  - One clock, CLK. Reset is asynchronous and active-low, on n_RES.
  - While n_RES=0: state=IDLE, phi_keep=1, en=0, d=0, cpu_ack=0, dbg_ack=0, addr_err=0, busy=0, rr_last=DBG (so the CPU wins the first tie).
- All outputs are registered.
- FSM states: IDLE, SETUP, OPEN, CLOSE, DONE.
- IDLE:
  - phi_keep=1, en=0; d holds its last value.
  - At an edge where at least one req=1, grant a requester:
    - only one requesting: grant it;
    - both requesting: grant the one not equal to rr_last, then set rr_last to the winner.
  - On grant, latch the granted addr/data into internal registers and go to SETUP.
- SETUP, one cycle:
  - d = latched data; en[addr]=1 if addr < NREGS, else en=0; phi_keep=1.
  - Next state OPEN.
- OPEN, OPEN_CYC cycles (counter):
  - phi_keep=0; d and en unchanged.
  - After the last cycle, go to CLOSE.
- CLOSE, one cycle:
  - phi_keep=1; en and d still held, so en falls strictly after phi_keep rises.
  - Next state DONE.
- DONE, one cycle:
  - en=0; the granted requester's ack=1; addr_err=1 if the address was out of range.
  - Next state IDLE. No grant is made in DONE.
  - The requester drops req during the ack cycle. A req still high in IDLE afterwards is treated as a new request.
- Timing:
  - Request seen at edge E0 → ack high in the cycle after edge E(OPEN_CYC+3).
  - Minimum spacing between grants is OPEN_CYC+4 cycles.
- Invariants:
  - en is zero or one-hot; never more than one bit set.
  - en changes only while phi_keep=1.
  - phi_keep=0 only in OPEN.
- Out-of-range address: full sequence is executed with en=0 (no latch disturbed), then ack and addr_err are pulsed.
- Request dropped mid-operation: the write completes and ack is still pulsed. Requesters must not drop req early.
- Reset mid-operation:
  - phi_keep goes to 1 and en to 0 immediately (asynchronous).
  - The write is aborted and no ack is issued.
  - The target latch contents are defined as whatever was loaded before reset.
- Simultaneous requests after a CPU win: debug is granted next, even if CPU re-requests.

Decomposition:
- Shared package: state enum (IDLE, SETUP, OPEN, CLOSE, DONE), requester id enum (CPU, DBG), and OPEN_CYC range limits.
- Sub-module wr_rr_arb2: two-request round-robin arbiter with an rr_last register. Outputs a grant id, updated only on an accept strobe from the FSM.
- The FSM, address decode and data/addr capture live in latch_wr_sched.

Test Plan:
- Reset, then cpu_req with addr=3, data=0xA5 (OPEN_CYC=1) → en=0x08 from SETUP through CLOSE; phi_keep low exactly 1 cycle; d=0xA5; cpu_ack pulse 5 cycles after request edge; a model sdffe bank holds 0xA5 at index 3.
- cpu_req and dbg_req asserted together, held (CPU addr 1, DBG addr 2) → CPU served first, DBG second, then CPU again; grants alternate.
- dbg_req with addr=7, NREGS=6 → en stays 0 for the whole sequence; dbg_ack and addr_err pulse together; no model latch changes.
- OPEN_CYC=3 with back-to-back CPU writes → phi_keep low 3 cycles per write; grants 7 cycles apart; check en-stable-across-phi_keep-edge assertion on every cycle.
- n_RES pulsed low during OPEN → phi_keep=1 and en=0 asynchronously; no ack; first request after reset is granted to CPU on a tie.
